// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: data width, named Alu16 control codes,
// FSM state type and the legal-code predicate.
package alu_pkg;

    localparam int ALU_W = 16;

    // Control bits are ordered zx,nx,zy,ny,f,no from MSB to LSB.
    localparam logic [5:0] C_ZERO    = 6'b101010;
    localparam logic [5:0] C_ONE     = 6'b111111;
    localparam logic [5:0] C_NEG1    = 6'b111010;
    localparam logic [5:0] C_X       = 6'b001100;
    localparam logic [5:0] C_Y       = 6'b110000;
    localparam logic [5:0] C_NOTX    = 6'b001101;
    localparam logic [5:0] C_NOTY    = 6'b110001;
    localparam logic [5:0] C_NEGX    = 6'b001111;
    localparam logic [5:0] C_NEGY    = 6'b110011;
    localparam logic [5:0] C_XPLUS1  = 6'b011111;
    localparam logic [5:0] C_YPLUS1  = 6'b110111;
    localparam logic [5:0] C_XMINUS1 = 6'b001110;
    localparam logic [5:0] C_YMINUS1 = 6'b110010;
    localparam logic [5:0] C_XPLUSY  = 6'b000010;
    localparam logic [5:0] C_XMINUSY = 6'b010011;
    localparam logic [5:0] C_YMINUSX = 6'b000111;
    localparam logic [5:0] C_XANDY   = 6'b000000;
    localparam logic [5:0] C_XORY    = 6'b010101;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic logic alu_c_legal(input logic [5:0] c);
        case (c)
            C_ZERO, C_ONE, C_NEG1, C_X, C_Y, C_NOTX, C_NOTY, C_NEGX, C_NEGY,
            C_XPLUS1, C_YPLUS1, C_XMINUS1, C_YMINUS1, C_XPLUSY, C_XMINUSY,
            C_YMINUSX, C_XANDY, C_XORY: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first asserted request found
// searching upward from (last+1) mod NREQ with wrap-around.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    input  logic            enable,
    output logic [NREQ-1:0] grant
);

    int   idx;
    logic found;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external Alu16 between NREQ requesters with round-robin arbitration.
// Define ALU_OP_CHECK_EN to reject illegal control codes with resp_err instead of executing them.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = ALU_W,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [6*NREQ-1:0] req_c,
    input  logic [W*NREQ-1:0] req_x,
    input  logic [W*NREQ-1:0] req_y,
    output logic [5:0]        alu_c,
    output logic [W-1:0]      alu_x,
    output logic [W-1:0]      alu_y,
    input  logic [W-1:0]      alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [W-1:0]      resp_data,
    output logic              resp_zr,
    output logic              resp_ng,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_err
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_q;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant;
    logic            take;
    logic            code_ok;
    logic [5:0]      sel_c;
    logic [W-1:0]    sel_x, sel_y;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req    (req_valid),
        .last   (last_q),
        .enable (state_q == IDLE),
        .grant  (grant)
    );

    assign req_ready  = grant;
    assign take       = |grant;
    assign resp_valid = (state_q == RESP);

    always_comb begin
        grant_idx = '0;
        sel_c     = '0;
        sel_x     = '0;
        sel_y     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDW'(i);
                sel_c     = req_c[6*i +: 6];
                sel_x     = req_x[W*i +: W];
                sel_y     = req_y[W*i +: W];
            end
        end
    end

`ifdef ALU_OP_CHECK_EN
    assign code_ok = alu_c_legal(sel_c);
`else
    assign code_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = code_ok ? EXEC : RESP;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= IDW'(NREQ - 1);
            alu_c     <= '0;
            alu_x     <= '0;
            alu_y     <= '0;
            resp_data <= '0;
            resp_zr   <= 1'b0;
            resp_ng   <= 1'b0;
            resp_id   <= '0;
            resp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && take) begin
                last_q   <= grant_idx;
                resp_id  <= grant_idx;
                resp_err <= !code_ok;
                if (code_ok) begin
                    alu_c <= sel_c;
                    alu_x <= sel_x;
                    alu_y <= sel_y;
                end else begin
                    // Rejected op: empty result, ALU operands left untouched.
                    resp_data <= '0;
                    resp_zr   <= 1'b0;
                    resp_ng   <= 1'b0;
                end
            end
            if (state_q == EXEC) begin
                resp_data <= alu_out;
                resp_zr   <= alu_zr;
                resp_ng   <= alu_ng;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: bit-level Alu16 stand-in, negedge monitor,
// and an arithmetic reference model of the ALU operations and round-robin order.
module tb_alu_arbiter;

    localparam int NREQ = 2;

    typedef struct {
        int              id;
        int              cyc;
        logic [NREQ-1:0] vld;
        logic [5:0]      c;
        logic [15:0]     x;
        logic [15:0]     y;
    } acc_t;

    typedef struct {
        int          id;
        int          rise;
        int          cyc;
        logic [15:0] d;
        logic        zr;
        logic        ng;
        logic        err;
    } rsp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid, req_ready;
    logic [6*NREQ-1:0]  req_c;
    logic [16*NREQ-1:0] req_x, req_y;
    logic [5:0]         alu_c;
    logic [15:0]        alu_x, alu_y, alu_out;
    logic               alu_zr, alu_ng;
    logic               resp_valid, resp_ready;
    logic [15:0]        resp_data;
    logic               resp_zr, resp_ng, resp_err;
    logic [1:0]         resp_id;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol  = 0;
    int rise_cyc = 0;
    logic prev_acc = 1'b0, prev_rv = 1'b0;
    logic [NREQ-1:0] acc_now = '0;
    acc_t acc_q[$];
    rsp_t rsp_q[$];
    acc_t mon_a;
    rsp_t mon_r;

    logic [5:0] legal_codes [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100,
        6'b110000, 6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111,
        6'b001110, 6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

    alu_arbiter #(.NREQ(NREQ), .W(16), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_c(req_c), .req_x(req_x), .req_y(req_y),
        .alu_c(alu_c), .alu_x(alu_x), .alu_y(alu_y),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_zr(resp_zr), .resp_ng(resp_ng), .resp_id(resp_id), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Bit-level Alu16 stand-in driven by the DUT's registered operands.
    logic [15:0] xs, ys, os;
    always_comb begin
        xs = alu_c[5] ? 16'h0 : alu_x;
        if (alu_c[4]) xs = ~xs;
        ys = alu_c[3] ? 16'h0 : alu_y;
        if (alu_c[2]) ys = ~ys;
        os = alu_c[1] ? xs + ys : xs & ys;
        if (alu_c[0]) os = ~os;
        alu_out = os;
        alu_zr  = (os == 16'h0);
        alu_ng  = os[15];
    end

    // Arithmetic meaning of each legal code.
    function automatic logic [15:0] ref_alu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            6'b101010: return 16'h0000;
            6'b111111: return 16'h0001;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return -x;
            6'b110011: return -y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'h0000;
        endcase
    endfunction

    always @(negedge clk) begin
        cyc++;
        acc_now = '0;
        if (!rst_n) begin
            prev_acc = 1'b0;
            prev_rv  = 1'b0;
        end else begin
            if ($countones(req_ready) > 1 || (req_ready != '0 && (resp_valid || prev_acc))) viol++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_a.id = i;  mon_a.cyc = cyc;  mon_a.vld = req_valid;
                    mon_a.c = req_c[6*i +: 6];  mon_a.x = req_x[16*i +: 16];  mon_a.y = req_y[16*i +: 16];
                    acc_q.push_back(mon_a);
                    acc_now[i] = 1'b1;
                end
            end
            if (resp_valid && !prev_rv) rise_cyc = cyc;
            if (resp_valid && resp_ready) begin
                mon_r.id = int'(resp_id);  mon_r.rise = rise_cyc;  mon_r.cyc = cyc;
                mon_r.d = resp_data;  mon_r.zr = resp_zr;  mon_r.ng = resp_ng;  mon_r.err = resp_err;
                rsp_q.push_back(mon_r);
            end
            prev_acc = (acc_now != '0);
            prev_rv  = resp_valid;
        end
    end

    task automatic issue(input int r, input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        bit got = 0;
        @(posedge clk); #1;
        req_c[6*r +: 6] = c;  req_x[16*r +: 16] = x;  req_y[16*r +: 16] = y;
        req_valid[r] = 1'b1;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (req_ready[r]) got = 1;
            @(posedge clk); #1;
        end
        req_valid[r] = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL accept_timeout req=%0d got=none want=accept", r); end
    endtask

    task automatic pop_pair(output acc_t a, output rsp_t r, output bit ok);
        ok = 0;
        for (int n = 0; n < 40 && rsp_q.size() == 0; n++) @(negedge clk);
        if (rsp_q.size() != 0 && acc_q.size() != 0) begin
            a = acc_q.pop_front();
            r = rsp_q.pop_front();
            ok = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;  req_valid = '0;  resp_ready = 1'b1;
        req_c = '0;  req_x = '0;  req_y = '0;
        #12;
        total++;
        if ({alu_c, alu_x, alu_y} !== 38'h0) begin
            bad++; $display("FAIL reset_alu got=%h want=0", {alu_c, alu_x, alu_y});
        end
        total++;
        if ({resp_valid, resp_data, resp_zr, resp_ng, resp_id, resp_err} !== 22'h0) begin
            bad++; $display("FAIL reset_resp got=%h want=0", {resp_valid, resp_data, resp_zr, resp_ng, resp_id, resp_err});
        end
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        acc_t a; rsp_t r; bit ok;
        acc_q.delete(); rsp_q.delete(); resp_ready = 1'b1;
        issue(0, 6'b000010, 16'h0005, 16'h0003);
        pop_pair(a, r, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_resp got=none want=response"); return; end
        total++;
        if ({r.d, r.zr, r.ng, r.err} !== {16'h0008, 3'b000} || r.id != 0) begin
            bad++; $display("FAIL single_data got=%h/%b%b%b id=%0d want=0008/000 id=0", r.d, r.zr, r.ng, r.err, r.id);
        end
        total++;
        if (r.rise - a.cyc != 2) begin bad++; $display("FAIL single_latency got=%0d want=2", r.rise - a.cyc); end
    endtask

    task automatic test_flags();
        acc_t a; rsp_t r; bit ok;
        acc_q.delete(); rsp_q.delete(); resp_ready = 1'b1;
        issue(1, 6'b010011, 16'h0003, 16'h0005);
        pop_pair(a, r, ok);
        total++;
        if (!ok || r.d !== 16'hFFFE || r.zr !== 1'b0 || r.ng !== 1'b1 || r.id != 1) begin
            bad++; $display("FAIL flags_neg got=%h zr=%b ng=%b id=%0d want=fffe zr=0 ng=1 id=1", r.d, r.zr, r.ng, r.id);
        end
        issue(1, 6'b101010, 16'h1234, 16'h5678);
        pop_pair(a, r, ok);
        total++;
        if (!ok || r.d !== 16'h0000 || r.zr !== 1'b1 || r.ng !== 1'b0) begin
            bad++; $display("FAIL flags_zero got=%h zr=%b ng=%b want=0000 zr=1 ng=0", r.d, r.zr, r.ng);
        end
    endtask

    task automatic test_round_robin();
        acc_t a; rsp_t r; bit ok;
        int base_viol = viol;
        int prev_cyc = 0;
        acc_q.delete(); rsp_q.delete(); resp_ready = 1'b1;
        @(posedge clk); #1;
        req_c = {6'b010011, 6'b000010};
        req_x = {16'd10, 16'd1};
        req_y = {16'd3, 16'd1};
        req_valid = 2'b11;
        for (int n = 0; n < 40 && acc_q.size() < 4; n++) begin @(posedge clk); #1; end
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            pop_pair(a, r, ok);
            total++;
            if (!ok || a.id != k % 2 || r.id != a.id || r.d !== ref_alu(a.c, a.x, a.y)) begin
                bad++; $display("FAIL rr_order k=%0d got id=%0d data=%h want id=%0d data=%h", k, r.id, r.d, k % 2, ref_alu(a.c, a.x, a.y));
            end
            if (k > 0) begin
                total++;
                if (a.cyc - prev_cyc != 3) begin bad++; $display("FAIL rr_throughput got=%0d want=3", a.cyc - prev_cyc); end
            end
            prev_cyc = a.cyc;
        end
        total++;
        if (viol != base_viol) begin bad++; $display("FAIL rr_ready_protocol got=%0d want=0", viol - base_viol); end
    endtask

    task automatic test_backpressure();
        acc_t a; rsp_t r; bit ok; bit seen = 0;
        logic [19:0] snap;
        int base_viol = viol;
        int hs_cyc = 0;
        acc_q.delete(); rsp_q.delete(); resp_ready = 1'b0;
        issue(0, 6'b000010, 16'h1111, 16'h2222);
        req_c[11:6] = 6'b001100;  req_x[31:16] = 16'h0BAD;  req_y[31:16] = 16'h0000;
        req_valid[1] = 1'b1;
        for (int n = 0; n < 10 && !seen; n++) begin @(negedge clk); if (resp_valid) seen = 1; end
        total++;
        if (!seen) begin bad++; $display("FAIL bp_resp got=none want=resp_valid"); end
        snap = {resp_data, resp_zr, resp_ng, resp_id};
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            total++;
            if ({resp_valid, resp_data, resp_zr, resp_ng, resp_id, req_ready} !== {1'b1, 20'h33330, 2'b00} ||
                snap !== 20'h33330) begin
                bad++; $display("FAIL bp_hold n=%0d got=%b %h want=1 33330 ready=00", n, resp_valid, {resp_data, resp_zr, resp_ng, resp_id});
            end
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        for (int n = 0; n < 10 && acc_q.size() < 2; n++) begin @(posedge clk); #1; end
        req_valid[1] = 1'b0;
        if (rsp_q.size() != 0) hs_cyc = rsp_q[0].cyc;
        total++;
        if (acc_q.size() < 2 || acc_q[1].id != 1 || acc_q[1].cyc - hs_cyc != 1) begin
            bad++; $display("FAIL bp_next_accept got=%0d accepts want=req1 one cycle after handshake", acc_q.size());
        end
        pop_pair(a, r, ok);
        pop_pair(a, r, ok);
        total++;
        if (!ok || r.d !== 16'h0BAD || r.id != 1) begin
            bad++; $display("FAIL bp_second got=%h id=%0d want=0bad id=1", r.d, r.id);
        end
        total++;
        if (viol != base_viol) begin bad++; $display("FAIL bp_ready_protocol got=%0d want=0", viol - base_viol); end
    endtask

    task automatic test_reset_mid_op();
        acc_t a; rsp_t r; bit ok;
        acc_q.delete(); rsp_q.delete(); resp_ready = 1'b1;
        issue(0, 6'b001100, 16'h00F0, 16'h0F00);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({alu_c, alu_x, alu_y} !== 38'h0) begin
            bad++; $display("FAIL midrst_alu got=%h want=0", {alu_c, alu_x, alu_y});
        end
        total++;
        if ({resp_valid, resp_data, resp_zr, resp_ng, resp_id, resp_err} !== 22'h0) begin
            bad++; $display("FAIL midrst_resp got=%h want=0", {resp_valid, resp_data, resp_zr, resp_ng, resp_id, resp_err});
        end
        @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
        acc_q.delete(); rsp_q.delete();
        repeat (6) @(negedge clk);
        total++;
        if (rsp_q.size() != 0) begin bad++; $display("FAIL midrst_ghost got=%0d responses want=0", rsp_q.size()); end
        @(posedge clk); #1;
        req_c = {6'b001100, 6'b110000};  req_x = {16'h0001, 16'h0002};  req_y = {16'h0003, 16'h0004};
        req_valid = 2'b11;
        for (int n = 0; n < 10 && acc_q.size() == 0; n++) begin @(posedge clk); #1; end
        req_valid = '0;
        pop_pair(a, r, ok);
        total++;
        if (!ok || a.id != 0 || r.id != 0 || r.d !== 16'h0004) begin
            bad++; $display("FAIL midrst_first_grant got id=%0d data=%h want id=0 data=0004", r.id, r.d);
        end
    endtask

    task automatic test_illegal_code();
        acc_t a; rsp_t r; bit ok;
        acc_q.delete(); rsp_q.delete(); resp_ready = 1'b1;
        issue(0, 6'b001100, 16'h1234, 16'h4321);
        pop_pair(a, r, ok);
        issue(0, 6'b100000, 16'hAAAA, 16'h5555);
        pop_pair(a, r, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL illegal_resp got=none want=response"); return; end
`ifdef ALU_OP_CHECK_EN
        total++;
        if ({r.err, r.d, r.zr, r.ng} !== {1'b1, 16'h0, 2'b00} || r.id != 0 || r.rise - a.cyc != 1) begin
            bad++; $display("FAIL illegal_err got err=%b d=%h id=%0d lat=%0d want err=1 d=0 id=0 lat=1", r.err, r.d, r.id, r.rise - a.cyc);
        end
        total++;
        if ({alu_c, alu_x} !== {6'b001100, 16'h1234}) begin
            bad++; $display("FAIL illegal_alu_kept got=%h want=%h", {alu_c, alu_x}, {6'b001100, 16'h1234});
        end
`else
        // 100000 zeroes x and ANDs with y, so the executed result is 0 with zr set.
        total++;
        if ({r.err, r.d, r.zr, r.ng} !== {1'b0, 16'h0, 2'b10} || r.id != 0 || r.rise - a.cyc != 2) begin
            bad++; $display("FAIL illegal_exec got err=%b d=%h zr=%b lat=%0d want err=0 d=0 zr=1 lat=2", r.err, r.d, r.zr, r.rise - a.cyc);
        end
        total++;
        if (alu_c !== 6'b100000) begin bad++; $display("FAIL illegal_alu_c got=%b want=100000", alu_c); end
`endif
    endtask

    task automatic test_random();
        acc_t a; rsp_t r;
        int last_m = NREQ - 1;
        int want_id;
        int base_viol;
        int n_pairs;
        @(posedge clk); #1 rst_n = 1'b0;
        req_valid = '0;
        #3 rst_n = 1'b1;
        acc_q.delete(); rsp_q.delete();
        base_viol = viol;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk); #1;
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (acc_now[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        req_c[6*i +: 6]   = legal_codes[$urandom_range(0, 17)];
                        req_x[16*i +: 16] = 16'($urandom);
                        req_y[16*i +: 16] = 16'($urandom);
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (acc_q.size() != rsp_q.size() || acc_q.size() < 20) begin
            bad++; $display("FAIL rand_count got acc=%0d rsp=%0d want equal and >=20", acc_q.size(), rsp_q.size());
        end
        n_pairs = (acc_q.size() < rsp_q.size()) ? acc_q.size() : rsp_q.size();
        for (int k = 0; k < n_pairs; k++) begin
            a = acc_q[k];
            r = rsp_q[k];
            want_id = -1;
            for (int s = 1; s <= NREQ && want_id < 0; s++)
                if (a.vld[(last_m + s) % NREQ]) want_id = (last_m + s) % NREQ;
            last_m = a.id;
            total++;
            if (a.id != want_id || r.id != a.id || r.d !== ref_alu(a.c, a.x, a.y) ||
                r.zr !== (ref_alu(a.c, a.x, a.y) == 16'h0) || r.ng !== ref_alu(a.c, a.x, a.y) >> 15 ||
                r.err !== 1'b0 || r.rise - a.cyc != 2) begin
                bad++;
                $display("FAIL rand_op k=%0d c=%b got id=%0d d=%h zr=%b ng=%b lat=%0d want id=%0d d=%h", k, a.c,
                         r.id, r.d, r.zr, r.ng, r.rise - a.cyc, want_id, ref_alu(a.c, a.x, a.y));
            end
        end
        total++;
        if (viol != base_viol) begin bad++; $display("FAIL rand_ready_protocol got=%0d want=0", viol - base_viol); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_op();
        test_flags();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_illegal_code();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational Alu16 (16-bit, 6-bit control ordered zx,nx,zy,ny,f,no) between NREQ requesters.
- Each requester presents a control code and operands with a valid/ready handshake.
- The block round-robin arbitrates, registers the operands onto the ALU, and captures the result and flags.
- It returns the result on one shared response channel tagged with the requester index. The ALU is instantiated alongside the block, not inside it.

Parameters:
- NREQ, 2, number of requesters (2..4).
- W, 16, data width; must match the ALU.
- IDW, 2, width of resp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_c  in  6*NREQ  packed control codes; requester i uses [6i+5:6i].
- req_x  in  W*NREQ  packed x operands.
- req_y  in  W*NREQ  packed y operands.
- alu_c  out  6  control code to the ALU.
- alu_x  out  W  x operand to the ALU.
- alu_y  out  W  y operand to the ALU.
- alu_out  in  W  ALU result.
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_data  out  W  registered result.
- resp_zr  out  1  registered zero flag.
- resp_ng  out  1  registered negative flag.
- resp_id  out  IDW  index of the requester served.
- resp_err  out  1  illegal control code (see Optional Feature).

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, alu_c=0, alu_x=0, alu_y=0, resp_valid=0, resp_data=0, resp_zr=0, resp_ng=0, resp_id=0, resp_err=0, rr pointer last=NREQ-1 (requester 0 has first priority).
- Reset mid-operation: the in-flight op is discarded, no response is produced, and the FSM returns to IDLE.
- FSM IDLE:
  - grant = first asserted req_valid searching from (last+1) mod NREQ upward with wrap.
  - req_ready = grant when state==IDLE, else 0. req_ready is combinational from req_valid and state.
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - On transfer: latch req_c/x/y[i] into alu_c/x/y, set id=i, set last=i, go to EXEC.
- FSM EXEC (one cycle): the ALU settles on the registered operands. At the edge, capture alu_out/zr/ng into resp_data/zr/ng, set resp_valid=1, go to RESP.
- FSM RESP:
  - Hold all resp_* stable while resp_valid && !resp_ready.
  - On resp_ready: resp_valid=0 and go to IDLE.
  - No request is accepted in EXEC or RESP.
- Timing: latency from the accept edge T to resp_valid high is edge T+2. Peak throughput is one op per 3 cycles when resp_ready is held at 1.
- Operands stay on alu_* until the next accept; they are not cleared.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 services.
- A requester dropping req_valid before acceptance is legal. A requester may change its operands while not granted.
- Unused requester indices beyond NREQ do not exist; resp_id never exceeds NREQ-1.

Optional Feature:
- Macro: ALU_OP_CHECK_EN.
- Defined: on accept, the code is checked against the 18 legal codes: 101010, 111111, 111010, 001100, 110000, 001101, 110001, 001111, 110011, 011111, 110111, 001110, 110010, 000010, 010011, 000111, 000000, 010101.
  - Illegal code: the FSM goes directly IDLE->RESP one edge after accept, skipping EXEC.
  - The response is resp_err=1, resp_data=0, resp_zr=0, resp_ng=0, with the correct resp_id. alu_c/x/y are not updated.
- Not defined: no checking is performed and resp_err is constant 0. Any code is executed.

Decomposition:
- Shared package alu_pkg holds:
  - width constant ALU_W=16.
  - named 6-bit control constants (C_ZERO=101010, C_ONE=111111, C_NEG1=111010, C_X=001100, ..., C_XORY=010101).
  - FSM state typedef {IDLE, EXEC, RESP}.
  - function alu_c_legal(c).
- One sub-module: rr_arbiter (NREQ), with inputs req, last, enable and output one-hot grant.

Test Plan:
- Single op: req0 c=000010, x=0x0005, y=0x0003, resp_ready=1 -> resp_valid at accept+2, resp_data=0x0008, zr=0, ng=0, id=0.
- Flags: req1 c=010011, x=3, y=5 -> resp_data=0xFFFE, ng=1, id=1. Then c=101010 -> resp_data=0, zr=1.
- Round-robin: both requesters valid continuously for 4 ops -> ids 0,1,0,1. req_ready is never asserted for both, and never asserted in EXEC/RESP.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_* stable and req_ready=0 throughout. When resp_ready rises, the next accept occurs the following cycle.
- Reset mid-op: assert rst_n=0 asynchronously during EXEC -> all outputs go to reset values immediately, with no response after release. The first grant after release goes to requester 0.
- With ALU_OP_CHECK_EN: req0 c=100000 -> resp at accept+1 with resp_err=1, resp_data=0, id=0, and alu_c unchanged. Without the macro, the same stimulus produces resp_err=0 at accept+2.
